// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, mid-bit sampling, optional parity, 1 or 2 stop bits.
// Define UART_RX_BREAK_DET_EN to enable break detection (otherwise break_det is tied 0).
module uart_rx_cfg #(
  parameter int BASE_FREQ = 50_000_000,
  parameter int BAUDRATE  = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] parallel_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 break_det
);

  localparam int unsigned CPB = BASE_FREQ / BAUDRATE;
  localparam int unsigned CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY_BIT = 3'd3,
    STOP       = 3'd4
  } state_t;

  state_t               state;
  logic                 sync1, sync2;
  logic [1:0]           sync_fill;
  logic                 armed;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 ferr_acc;
  logic                 perr_calc;

  always_comb begin
    perr_calc = 1'b0;
    if (PARITY == 1)
      perr_calc = ^shreg ^ par_bit;
    else if (PARITY == 2)
      perr_calc = ~(^shreg ^ par_bit);
  end

`ifdef UART_RX_BREAK_DET_EN
  logic brk_flag, brk_wait, brk_cond, brk_now;

  // Break qualifies on the first stop bit; with two stop bits it is remembered until the last one.
  assign brk_cond = (shreg == '0) && ((PARITY == 0) || !par_bit) && !sync2;
  assign brk_now  = (bit_cnt == '0) ? brk_cond : brk_flag;
`else
  assign break_det = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      sync_fill    <= '0;
      armed        <= 1'b0;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      ferr_acc     <= 1'b0;
      parallel_out <= '0;
      data_valid   <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det    <= 1'b0;
      brk_flag     <= 1'b0;
      brk_wait     <= 1'b0;
`endif
    end else begin
      sync1      <= serial_in;
      sync2      <= sync1;
      sync_fill  <= {sync_fill[0], 1'b1};
      // The reset value of the synchroniser must not count as having seen the line high.
      if (sync_fill[1] && sync2)
        armed <= 1'b1;
      data_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      break_det  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (armed && !sync2) begin
            state    <= START;
            busy     <= 1'b1;
            cnt      <= '0;
            bit_cnt  <= '0;
            ferr_acc <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (sync2) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PARITY_BIT : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY_BIT: begin
          if (cnt == FULL) begin
            cnt     <= '0;
            par_bit <= sync2;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
`ifdef UART_RX_BREAK_DET_EN
          if (brk_wait) begin
            if (sync2) begin
              brk_wait <= 1'b0;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end else
`endif
          if (cnt == FULL) begin
            cnt <= '0;
            if (bit_cnt == LAST_STOP) begin
              parallel_out <= shreg;
              parity_err   <= perr_calc;
              frame_err    <= ferr_acc | ~sync2;
              data_valid   <= 1'b1;
`ifdef UART_RX_BREAK_DET_EN
              if (brk_now) begin
                break_det <= 1'b1;
                brk_wait  <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              ferr_acc <= ferr_acc | ~sync2;
`ifdef UART_RX_BREAK_DET_EN
              if (bit_cnt == '0)
                brk_flag <= brk_cond;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at CPB=16.
module tb_uart_rx_cfg;

  localparam int CPB = 16;
`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] line;

  logic [7:0] po0, po2;
  logic [6:0] po1;
  logic dv0, pe0, fe0, bz0, bd0;
  logic dv1, pe1, fe1, bz1, bd1;
  logic dv2, pe2, fe2, bz2, bd2;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         fall;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic pdv0 = 1'b0, pdv1 = 1'b0, pdv2 = 1'b0;

  uart_rx_cfg #(.BASE_FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .serial_in(line[0]), .parallel_out(po0), .data_valid(dv0),
    .parity_err(pe0), .frame_err(fe0), .busy(bz0), .break_det(bd0));

  uart_rx_cfg #(.BASE_FREQ(16), .BAUDRATE(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .serial_in(line[1]), .parallel_out(po1), .data_valid(dv1),
    .parity_err(pe1), .frame_err(fe1), .busy(bz1), .break_det(bd1));

  uart_rx_cfg #(.BASE_FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .serial_in(line[2]), .parallel_out(po2), .data_valid(dv2),
    .parity_err(pe2), .frame_err(fe2), .busy(bz2), .break_det(bd2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic score(input int which, input logic dv, input logic [8:0] data,
                       input logic pe, input logic fe, input logic bd);
    exp_t e;
    bit   have;
    int   lat, latv;
    have = 1'b0;
    case (which)
      0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      check($sformatf("u%0d_unexpected_dv", which), 32'(dv), 32'd0);
      return;
    end
    check($sformatf("u%0d_data", which), 32'(data), 32'(e.data));
    check($sformatf("u%0d_parity_err", which), 32'(pe), 32'(e.perr));
    check($sformatf("u%0d_frame_err", which), 32'(fe), 32'(e.ferr));
    check($sformatf("u%0d_break_det", which), 32'(bd), 32'(e.brk));
    lat  = cyc - e.fall;
    latv = (lat >= e.lat - 1 && lat <= e.lat + 1) ? e.lat : lat;
    check($sformatf("u%0d_latency", which), 32'(latv), 32'(e.lat));
  endtask

  always @(negedge clk) begin
    if (pdv0) check("u0_dv_pulse", 32'(dv0), 32'd0);
    if (pdv1) check("u1_dv_pulse", 32'(dv1), 32'd0);
    if (pdv2) check("u2_dv_pulse", 32'(dv2), 32'd0);
    pdv0 = dv0;
    pdv1 = dv1;
    pdv2 = dv2;
    if (dv0) score(0, dv0, {1'b0, po0}, pe0, fe0, bd0);
    if (dv1) score(1, dv1, {2'b0, po1}, pe1, fe1, bd1);
    if (dv2) score(2, dv2, {1'b0, po2}, pe2, fe2, bd2);
  end

  task automatic hold(input int which, input logic v, input int n);
    line[which] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int which, input logic [8:0] data, input int nd, input int use_par,
                      input logic par_bit, input int nstop, input logic [1:0] stops);
    exp_t e;
    e.data = data;
    e.perr = (use_par != 0) ? (^data ^ par_bit) : 1'b0;
    e.ferr = ~stops[0] | ((nstop == 2) && ~stops[1]);
    e.brk  = BRK && (data == '0) && ((use_par == 0) || !par_bit) && !stops[0];
    e.fall = cyc;
    e.lat  = 3 + CPB / 2 + CPB * (nd + ((use_par != 0) ? 1 : 0) + nstop);
    case (which)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Last stop bit is cut short so a low final stop cannot be mistaken for a new start bit.
  task automatic send(input int which, input logic [8:0] data, input int nd, input int use_par,
                      input logic par_bit, input int nstop, input logic [1:0] stops);
    push(which, data, nd, use_par, par_bit, nstop, stops);
    hold(which, 1'b0, CPB);
    for (int i = 0; i < nd; i++) hold(which, data[i], CPB);
    if (use_par != 0) hold(which, par_bit, CPB);
    for (int i = 0; i < nstop; i++) hold(which, stops[i], (i == nstop - 1) ? CPB / 2 + 4 : CPB);
    line[which] = 1'b1;
  endtask

  task automatic drain(input int which, input int budget);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("u%0d_drain", which), 32'(qsize(which)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst  = 1'b0;
    line = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_po0", 32'(po0), 32'd0);
    check("rst_dv0", 32'(dv0), 32'd0);
    check("rst_flags0", 32'({pe0, fe0, bz0, bd0}), 32'd0);
    check("rst_po1", 32'(po1), 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 patterns, including back-to-back frames
    send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11);
    hold(0, 1'b1, CPB);
    send(0, 9'h000, 8, 0, 1'b0, 1, 2'b11);
    send(0, 9'h0FF, 8, 0, 1'b0, 1, 2'b11);
    send(0, 9'h001, 8, 0, 1'b0, 1, 2'b11);
    hold(0, 1'b1, 3);
    send(0, 9'h080, 8, 0, 1'b0, 1, 2'b11);
    drain(0, 400);
    hold(0, 1'b1, 2 * CPB);
    check("u0_hold_data", 32'(po0), 32'h80);

    // 7E1 parity
    send(1, 9'h07F, 7, 1, 1'b1, 1, 2'b11);
    hold(1, 1'b1, CPB);
    send(1, 9'h041, 7, 1, 1'b0, 1, 2'b11);
    hold(1, 1'b1, 2 * CPB);
    send(1, 9'h041, 7, 1, 1'b1, 1, 2'b11);
    drain(1, 400);
    hold(1, 1'b1, 3 * CPB);
    check("u1_hold_perr", 32'(pe1), 32'd1);
    check("u1_hold_data", 32'(po1), 32'h41);

    // 8N2 stop-bit checking
    send(2, 9'h03C, 8, 0, 1'b0, 2, 2'b01);
    hold(2, 1'b1, 3 * CPB);
    send(2, 9'h0C3, 8, 0, 1'b0, 2, 2'b11);
    hold(2, 1'b1, CPB);
    send(2, 9'h03C, 8, 0, 1'b0, 2, 2'b10);
    drain(2, 400);
    hold(2, 1'b1, 3 * CPB);
    check("u2_hold_ferr", 32'(fe2), 32'd1);

    // 5-cycle glitch on idle line
    hold(0, 1'b0, 4);
    check("glitch_busy_hi", 32'(bz0), 32'd1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, CPB / 2 + 3);
    check("glitch_busy_lo", 32'(bz0), 32'd0);
    hold(0, 1'b1, 2 * CPB);

    // reset in the middle of data bit 4 (bit 4 low, line stays low after release)
    hold(0, 1'b0, CPB);
    hold(0, 1'b1, 4 * CPB);
    hold(0, 1'b0, CPB / 2);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_po0", 32'(po0), 32'd0);
    check("midrst_flags0", 32'({dv0, pe0, fe0, bz0, bd0}), 32'd0);
    rst = 1'b1;
    hold(0, 1'b0, 2 * CPB);
    check("midrst_not_armed", 32'(bz0), 32'd0);
    hold(0, 1'b1, 2 * CPB);
    send(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
    drain(0, 400);
    hold(0, 1'b1, 2 * CPB);

    // line held low (break)
`ifdef UART_RX_BREAK_DET_EN
    push(0, 9'h000, 8, 0, 1'b0, 1, 2'b00);
    hold(0, 1'b0, 200);
    check("brk_busy_wait1", 32'(bz0), 32'd1);
    hold(0, 1'b0, 3 * 10 * CPB - 200);
    check("brk_busy_wait2", 32'(bz0), 32'd1);
    hold(0, 1'b1, 8);
    check("brk_busy_release", 32'(bz0), 32'd0);
    send(0, 9'h05A, 8, 0, 1'b0, 1, 2'b11);
`else
    push(0, 9'h000, 8, 0, 1'b0, 1, 2'b00);
    hold(0, 1'b0, 10 * CPB);
    hold(0, 1'b1, 3 * CPB);
    check("brk_off_busy", 32'(bz0), 32'd0);
`endif
    drain(0, 400);
    hold(0, 1'b1, 2 * CPB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
